// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// synchronous flush (bubble insertion) and a saturating stall-cycle counter.
// Ports: clock/reset (async, active-high); flush squashes stage contents;
// in_valid/in_ready/in_ctrl/in_data upstream beat; out_valid/out_ready/out_ctrl/
// out_data registered downstream beat (out_ctrl zero while out_valid=0);
// stall_cnt counts cycles with out_valid && !out_ready, saturating.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]           stall_cnt
);
    localparam int DW = NUM_DATA * DATA_W;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              main_free, acc;
    assign main_free = !valid_q || out_ready;
    assign acc       = in_valid && in_ready;
    assign stall_d   = (valid_q && !out_ready && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;
    // Ready is purely a flop: the stage can take a beat whenever the skid slot is free.
    assign in_ready = !skid_valid_q;
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // A full skid means in_ready was low, so no new beat competes with it.
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = acc;
                ctrl_d  = acc ? in_ctrl : '0;
                data_d  = acc ? in_data : data_q;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = main_free;
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (main_free) begin
            valid_d = acc;
            ctrl_d  = acc ? in_ctrl : '0;
            data_d  = acc ? in_data : data_q;
        end
    end
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end
    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg (CNT_W=4).
module tb_pipe_stage_reg;
    localparam int CW = 8, DW = 32, ND = 4, CNTW = 4, W = ND * DW;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    typedef struct packed {
        logic [CW-1:0] c;
        logic [W-1:0]  d;
    } beat_t;

    logic            clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0]   in_ctrl = '0;
    logic [W-1:0]    in_data = '0;
    logic            in_ready, out_valid;
    logic [CW-1:0]   out_ctrl;
    logic [W-1:0]    out_data;
    logic [CNTW-1:0] stall_cnt;

    beat_t q[$];
    int stall_m = 0;
    int n_chk = 0, n_fail = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND), .CNT_W(CNTW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] r;
        for (int i = 0; i < ND; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic check_out();
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_ctrl", W'(out_ctrl), W'(q[0].c));
            chk("out_data", out_data, q[0].d);
        end else begin
            chk("bubble_ctrl", W'(out_ctrl), '0);
        end
        chk("stall_cnt", W'(stall_cnt), W'(stall_m));
    endtask

    // One cycle, starting and ending at a falling edge.
    task automatic cyc(input logic iv, input logic [CW-1:0] c, input logic ordy, input logic fl);
        logic rdy_m, acc, outx;
        logic [W-1:0] d;
        beat_t b;
        d = rnd_data();
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        rdy_m = q.size() < 2;
`else
        rdy_m = (q.size() == 0) || ordy;
`endif
        chk("in_ready", W'(in_ready), W'(rdy_m));
        acc  = iv && rdy_m;
        outx = (q.size() > 0) && ordy;
        if (q.size() > 0 && !ordy && stall_m < 15) stall_m++;
        @(posedge clock);
        if (fl) q.delete();
        else begin
            if (outx) q.delete(0);
            if (acc) begin
                b.c = c; b.d = d;
                q.push_back(b);
            end
        end
        @(negedge clock);
        check_out();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_ctrl", W'(out_ctrl), '0);
        chk("rst_data", out_data, '0);
        chk("rst_stall", W'(stall_cnt), '0);
        chk("rst_ready", W'(in_ready), W'(1));
        reset = 1'b0;
        @(negedge clock);

        // Async reset mid-stall
        cyc(1, 8'h11, 1, 0);
        repeat (5) cyc(0, 8'h00, 0, 0);
        chk("stall_five", W'(stall_cnt), W'(5));
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", W'(out_valid), '0);
        chk("arst_ctrl", W'(out_ctrl), '0);
        chk("arst_data", out_data, '0);
        chk("arst_stall", W'(stall_cnt), '0);
        q.delete();
        stall_m = 0;
        #1 reset = 1'b0;
        @(negedge clock);

        // Streaming
        for (int i = 1; i <= 10; i++) cyc(1, CW'(i), 1, 0);
        cyc(0, 8'h00, 1, 0);

        // Bubble mid-stream
        cyc(1, 8'h21, 1, 0);
        cyc(0, 8'hAA, 1, 0);
        cyc(1, 8'h22, 1, 0);
        cyc(0, 8'h00, 1, 0);

        // Backpressure
        cyc(1, 8'h31, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, CW'(8'h32 + i), 0, 0);
        chk("bp_stall4", W'(stall_cnt), W'(4));
        n = 0;
        repeat (3) begin
            if (out_valid) n++;
            cyc(0, 8'h00, 1, 0);
        end
        chk("bp_beats", W'(n), W'(CAP));

        // Flush with a concurrent incoming beat
        cyc(1, 8'hFF, 1, 0);
        cyc(1, 8'h3C, 0, 1);
        chk("flush_valid", W'(out_valid), '0);
        chk("flush_ctrl", W'(out_ctrl), '0);
        cyc(0, 8'h00, 1, 0);
        chk("flush_no3c", W'(out_valid), '0);

        // Saturation
        cyc(1, 8'h55, 1, 0);
        repeat (20) cyc(0, 8'h00, 0, 0);
        chk("stall_sat", W'(stall_cnt), W'(15));
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
